prio_rr_arbiter: RTL and testbench

Parametrised multi-level priority arbiter with round-robin tie-break, valid/ready output handshake and lock-in of the pending decision. It succeeds the fixed-priority arbiter in common_cells for shared-resource front ends (memory ports, interconnect muxes) that need per-requester priority levels and fairness. An optional aging mechanism prevents starvation of low-priority requesters.

---
 rtl/prio_rr_arbiter.sv | 117 +++++++++++
 tb/tb_prio_rr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/prio_rr_arbiter.sv
// Multi-level priority arbiter, round-robin tie-break, decision lock; define ARB_AGING_EN for anti-starvation aging.
// Latency: decision is combinational, rdy_i->gnt_o zero latency; pointer/lock/aging update on the next clk_i edge.
// Backpressure: with LOCK_IN the presented decision is held until rdy_i; otherwise re-arbitrates every cycle.
module prio_rr_arbiter #(
    parameter int unsigned NUM_REQ  = 8,
    parameter int unsigned PRIO_W   = 2,
    parameter bit          LOCK_IN  = 1'b1,
    parameter int unsigned MAX_WAIT = 15,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*PRIO_W-1:0] prio_i,
    input  logic                      rdy_i,
    output logic                      vld_o,
    output logic [IDX_W-1:0]          idx_o,
    output logic [NUM_REQ-1:0]        gnt_o
);

    logic                           lock_q;
    logic [IDX_W-1:0]               lock_idx_q;
    logic [IDX_W-1:0]               rr_ptr_q;
    logic [NUM_REQ-1:0]             starving;
    logic [NUM_REQ-1:0][PRIO_W:0]   lvl;
    logic [PRIO_W:0]                max_lvl;
    logic [IDX_W-1:0]               win_hi;
    logic [IDX_W-1:0]               win_lo;
    logic                           found_hi;
    logic [IDX_W-1:0]               winner;
    logic                           xfer;

`ifdef ARB_AGING_EN
    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CNT_W-1:0] wait_cnt_q [NUM_REQ];

    always_comb begin
        starving = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starving[i] = (wait_cnt_q[i] == CNT_W'(MAX_WAIT));
        end
    end

    // Only losses on an actual transfer age a requester; idle or stalled cycles do not.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_i || flush_i || !req_i[i] || gnt_o[i]) begin
                wait_cnt_q[i] <= '0;
            end else if (xfer && (wait_cnt_q[i] != CNT_W'(MAX_WAIT))) begin
                wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
            end
        end
    end
`else
    assign starving = '0;
`endif

    // Starving requesters get the extra MSB, placing them above every normal level.
    always_comb begin
        lvl      = '0;
        max_lvl  = '0;
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            lvl[i] = {starving[i], prio_i[i*PRIO_W +: PRIO_W]};
            if (req_i[i] && (lvl[i] > max_lvl)) begin
                max_lvl = lvl[i];
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i] && (lvl[i] == max_lvl)) begin
                win_lo = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr_q) begin
                    win_hi   = IDX_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        gnt_o = '0;
        if (!rst_i) begin
            vld_o = lock_q | (|req_i);
            idx_o = lock_q ? lock_idx_q : winner;
            for (int i = 0; i < NUM_REQ; i++) begin
                gnt_o[i] = vld_o && rdy_i && (idx_o == IDX_W'(i));
            end
        end
    end

    assign xfer = vld_o & rdy_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else if (flush_i) begin
            lock_q   <= 1'b0;
            rr_ptr_q <= '0;
        end else if (xfer) begin
            lock_q   <= 1'b0;
            rr_ptr_q <= (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
        end else if (LOCK_IN && vld_o && !lock_q) begin
            lock_q     <= 1'b1;
            lock_idx_q <= winner;
        end
    end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Self-checking bench for prio_rr_arbiter (NUM_REQ=4): directed scenarios plus randomized traffic against a reference model.
module tb_prio_rr_arbiter;
    localparam int N  = 4;
    localparam int PW = 2;
    localparam int MW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, flush, rdy;
    logic [N-1:0]    req;
    logic [N*PW-1:0] prio;
    logic            vld;
    logic [1:0]      idx;
    logic [N-1:0]    gnt;

    int checks   = 0;
    int failures = 0;

    bit m_lock;
    int m_lock_idx;
    int m_ptr;
    int m_cnt [N];

    prio_rr_arbiter #(.NUM_REQ(N), .PRIO_W(PW), .LOCK_IN(1'b1), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_i(req), .prio_i(prio),
        .rdy_i(rdy), .vld_o(vld), .idx_o(idx), .gnt_o(gnt)
    );

    function automatic int lvl_of(int i);
        int l;
        l = int'(prio[i*PW +: PW]);
`ifdef ARB_AGING_EN
        if (m_cnt[i] == MW) l = l + (1 << PW);
`endif
        return l;
    endfunction

    // Highest level wins; ties go to the first requester met scanning upward from the pointer.
    function automatic int m_pick();
        int best = -1;
        for (int i = 0; i < N; i++)
            if (req[i] && lvl_of(i) > best) best = lvl_of(i);
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            if (req[j] && lvl_of(j) == best) return j;
        end
        return 0;
    endfunction

    task automatic m_exp(output bit ev, output int ei, output logic [N-1:0] eg);
        if (rst) begin
            ev = 1'b0; ei = 0;
        end else if (m_lock) begin
            ev = 1'b1; ei = m_lock_idx;
        end else begin
            ev = |req; ei = ev ? m_pick() : 0;
        end
        eg = '0;
        if (ev && rdy) eg[ei] = 1'b1;
    endtask

    task automatic advance();
        bit ev; int ei; logic [N-1:0] eg; bit xfer;
        if (!rst && m_lock) assert (req[m_lock_idx]) else $error("protocol: locked requester dropped its request");
        m_exp(ev, ei, eg);
        xfer = ev && rdy;
        if (rst || flush) begin
            if (rst) m_lock_idx = 0;
            m_lock = 1'b0; m_ptr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || (xfer && ei == i)) m_cnt[i] = 0;
                else if (xfer && m_cnt[i] < MW) m_cnt[i]++;
            end
            if (xfer) begin
                m_ptr = (ei + 1) % N; m_lock = 1'b0;
            end else if (ev && !m_lock) begin
                m_lock = 1'b1; m_lock_idx = ei;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req = 4'hF; prio = 8'h1B; rdy = 1'b1;
        #1;
        checks++; if (vld !== 1'b0) begin failures++; $display("FAIL reset_vld got %b want 0", vld); end
        checks++; if (idx !== 2'd0) begin failures++; $display("FAIL reset_idx got %0d want 0", idx); end
        checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        advance();
        rst = 1'b0; req = 4'h0;
        #1;
        checks++; if (vld !== 1'b0) begin failures++; $display("FAIL idle_vld got %b want 0", vld); end
        checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL idle_gnt got %b want 0000", gnt); end
        advance();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'hF; prio = 8'h00; rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (gnt !== exp_g[c]) begin failures++; $display("FAIL rr_gnt cycle %0d got %b want %b", c, gnt, exp_g[c]); end
            advance();
        end
    endtask

    task automatic test_priority();
        req = 4'b0101; prio = 8'b00_11_00_01; rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (idx !== 2'd2) begin failures++; $display("FAIL prio_idx cycle %0d got %0d want 2", c, idx); end
            checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL prio_gnt cycle %0d got %b want 0100", c, gnt); end
            advance();
        end
    endtask

    task automatic test_lock();
        logic [3:0] t_req [4];
        logic [7:0] t_prio [4];
        logic [3:0] t_gnt [4];
        t_req  = '{4'b0001, 4'b1001, 4'b1001, 4'b1001};
        t_prio = '{8'h00, 8'hC0, 8'hC0, 8'hC0};
        t_gnt  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
        for (int c = 0; c < 4; c++) begin
            req = t_req[c]; prio = t_prio[c]; rdy = (c == 3);
            #1;
            checks++; if (vld !== 1'b1) begin failures++; $display("FAIL lock_vld cycle %0d got %b want 1", c, vld); end
            checks++; if (idx !== 2'd0) begin failures++; $display("FAIL lock_idx cycle %0d got %0d want 0", c, idx); end
            checks++; if (gnt !== t_gnt[c]) begin failures++; $display("FAIL lock_gnt cycle %0d got %b want %b", c, gnt, t_gnt[c]); end
            advance();
        end
        req = 4'b1000;
        #1;
        checks++; if (idx !== 2'd3) begin failures++; $display("FAIL lock_after_idx got %0d want 3", idx); end
        advance();
    endtask

    task automatic test_flush();
        req = 4'b0010; prio = 8'h00; rdy = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL flush_pre_gnt got %b want 0010", gnt); end
        advance();
        req = 4'b0100; rdy = 1'b0;
        #1;
        checks++; if (idx !== 2'd2) begin failures++; $display("FAIL flush_lockon_idx got %0d want 2", idx); end
        advance();
        req = 4'hF; flush = 1'b1;
        #1;
        checks++; if (idx !== 2'd2 || vld !== 1'b1) begin failures++; $display("FAIL flush_cycle got idx=%0d vld=%b want idx=2 vld=1", idx, vld); end
        advance();
        flush = 1'b0;
        #1;
        checks++; if (idx !== 2'd0) begin failures++; $display("FAIL flush_after_idx got %0d want 0", idx); end
        advance();
        rdy = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL flush_after_gnt got %b want 0001", gnt); end
        advance();
    endtask

    task automatic test_aging();
        logic [3:0] exp_g [5];
`ifdef ARB_AGING_EN
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
`else
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
        flush = 1'b1; req = 4'h0; rdy = 1'b0;
        advance();
        flush = 1'b0; req = 4'b0011; prio = 8'b00_00_11_00; rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (gnt !== exp_g[c]) begin failures++; $display("FAIL aging_gnt cycle %0d got %b want %b", c, gnt, exp_g[c]); end
            advance();
        end
    endtask

    task automatic test_reset_midlock();
        req = 4'b0110; prio = 8'h00; rdy = 1'b0;
        #1;
        checks++; if (idx !== 2'd2) begin failures++; $display("FAIL midlock_idx got %0d want 2", idx); end
        advance();
        rst = 1'b1;
        #1;
        checks++; if (vld !== 1'b0 || idx !== 2'd0 || gnt !== 4'b0) begin failures++; $display("FAIL midlock_rst got vld=%b idx=%0d gnt=%b want 0/0/0000", vld, idx, gnt); end
        advance();
        rst = 1'b0;
        #1;
        checks++; if (vld !== 1'b1 || idx !== 2'd1) begin failures++; $display("FAIL midlock_after got vld=%b idx=%0d want vld=1 idx=1", vld, idx); end
        advance();
        rdy = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL midlock_gnt got %b want 0010", gnt); end
        advance();
    endtask

    task automatic test_random();
        bit ev; int ei; logic [N-1:0] eg;
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(99) == 0);
            flush = ($urandom_range(99) < 3);
            rdy   = ($urandom_range(99) < 55);
            req   = 4'($urandom);
            prio  = 8'($urandom);
            if (m_lock) req[m_lock_idx] = 1'b1;
            #1;
            m_exp(ev, ei, eg);
            checks++; if (vld !== ev) begin failures++; $display("FAIL rand_vld cycle %0d got %b want %b", c, vld, ev); end
            checks++; if (idx !== 2'(ei)) begin failures++; $display("FAIL rand_idx cycle %0d got %0d want %0d", c, idx, ei); end
            checks++; if (gnt !== eg) begin failures++; $display("FAIL rand_gnt cycle %0d got %b want %b", c, gnt, eg); end
            advance();
        end
    endtask

    initial begin
        m_lock = 1'b0; m_lock_idx = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        test_reset();
        test_round_robin();
        test_priority();
        test_lock();
        test_flush();
        test_aging();
        test_reset_midlock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
